// File: rtl/integrator.sv
// rtl/integrator.sv - leaky signed integrator with a saturating accumulator and a one-deep output register
module integrator #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int ACC_WIDTH        = 32,
  parameter int LEAK_SHIFT       = 10,
  parameter int OUT_SHIFT        = 8
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic                               clear,
  input  logic                               S_AXIS_tvalid,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                               S_AXIS_tready,
  output logic                               M_AXIS_tvalid,
  output logic signed [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  input  logic                               M_AXIS_tready,
  output logic                               sat_flag
);

  // Two guard bits let acc - leak + sample be formed without overflow before clipping.
  localparam int EW = ACC_WIDTH + 2;
  localparam int DW = AXIS_TDATA_WIDTH;

  localparam logic signed [EW-1:0] ACC_MAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] ACC_MIN = {3'b111, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = {{(ACC_WIDTH-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] leak;
  logic signed [EW-1:0]        sum;
  logic signed [ACC_WIDTH-1:0] acc_new;
  logic signed [ACC_WIDTH-1:0] out_full;
  logic signed [DW-1:0]        out_sat;
  logic                        acc_clip;
  logic                        out_clip;
  logic                        accept;

  // Ready depends only on the output register state, never on S_AXIS_tvalid.
  assign S_AXIS_tready = !M_AXIS_tvalid || M_AXIS_tready;
  assign accept        = S_AXIS_tvalid && S_AXIS_tready;

  // A clear coinciding with an accept restarts integration from zero on this very sample.
  assign acc_base = clear ? '0 : acc;

  if (LEAK_SHIFT == 0) begin : g_no_leak
    assign leak = '0;
  end else begin : g_leak
    assign leak = acc_base >>> LEAK_SHIFT;
  end

  // Wide sum, clip to the accumulator range, then scale and clip to the sample range.
  always_comb begin
    sum = {{2{acc_base[ACC_WIDTH-1]}}, acc_base}
        - {{2{leak[ACC_WIDTH-1]}}, leak}
        + {{(EW-DW){S_AXIS_tdata[DW-1]}}, S_AXIS_tdata};
    acc_clip = 1'b0;
    if (sum > ACC_MAX) begin
      acc_new  = ACC_MAX[ACC_WIDTH-1:0];
      acc_clip = 1'b1;
    end else if (sum < ACC_MIN) begin
      acc_new  = ACC_MIN[ACC_WIDTH-1:0];
      acc_clip = 1'b1;
    end else begin
      acc_new = sum[ACC_WIDTH-1:0];
    end
    out_full = acc_new >>> OUT_SHIFT;
    out_clip = 1'b0;
    if (out_full > OUT_MAX) begin
      out_sat  = OUT_MAX[DW-1:0];
      out_clip = 1'b1;
    end else if (out_full < OUT_MIN) begin
      out_sat  = OUT_MIN[DW-1:0];
      out_clip = 1'b1;
    end else begin
      out_sat = out_full[DW-1:0];
    end
  end

  // Accumulator, output register and sticky saturation flag; reset dominates clear and handshakes.
  always_ff @(posedge aclk) begin
    if (areset) begin
      acc           <= '0;
      M_AXIS_tdata  <= '0;
      M_AXIS_tvalid <= 1'b0;
      sat_flag      <= 1'b0;
    end else if (accept) begin
      acc           <= acc_new;
      M_AXIS_tdata  <= out_sat;
      M_AXIS_tvalid <= 1'b1;
      sat_flag      <= (clear ? 1'b0 : sat_flag) | acc_clip | out_clip;
    end else begin
      if (M_AXIS_tvalid && M_AXIS_tready) begin
        M_AXIS_tvalid <= 1'b0;
      end
      if (clear) begin
        acc      <= '0;
        sat_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_integrator.sv
// tb/tb_integrator.sv - directed self-checking bench for integrator
module tb_integrator;

  logic               aclk;
  logic               areset;
  logic               clear;
  logic               s_tvalid;
  logic signed [15:0] s_tdata;
  logic               m_tready;

  logic               p_sready, p_mvalid, p_sat;
  logic signed [15:0] p_mdata;
  logic               l_sready, l_mvalid, l_sat;
  logic signed [15:0] l_mdata;
  logic               s_sready, s_mvalid, s_sat;
  logic signed [15:0] s_mdata;

  int errors = 0;
  int checks = 0;

  integrator #(.AXIS_TDATA_WIDTH(16), .ACC_WIDTH(32), .LEAK_SHIFT(0), .OUT_SHIFT(0)) u_pure (
    .aclk(aclk), .areset(areset), .clear(clear),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata), .S_AXIS_tready(p_sready),
    .M_AXIS_tvalid(p_mvalid), .M_AXIS_tdata(p_mdata), .M_AXIS_tready(m_tready),
    .sat_flag(p_sat)
  );

  integrator #(.AXIS_TDATA_WIDTH(16), .ACC_WIDTH(32), .LEAK_SHIFT(1), .OUT_SHIFT(0)) u_leak (
    .aclk(aclk), .areset(areset), .clear(clear),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata), .S_AXIS_tready(l_sready),
    .M_AXIS_tvalid(l_mvalid), .M_AXIS_tdata(l_mdata), .M_AXIS_tready(m_tready),
    .sat_flag(l_sat)
  );

  integrator #(.AXIS_TDATA_WIDTH(16), .ACC_WIDTH(20), .LEAK_SHIFT(0), .OUT_SHIFT(0)) u_sat (
    .aclk(aclk), .areset(areset), .clear(clear),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata), .S_AXIS_tready(s_sready),
    .M_AXIS_tvalid(s_mvalid), .M_AXIS_tdata(s_mdata), .M_AXIS_tready(m_tready),
    .sat_flag(s_sat)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset   = 1'b1;
    clear    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    tick();
    areset   = 1'b0;
  endtask

  task automatic test_reset();
    areset   = 1'b1;
    clear    = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 16'sd123;
    m_tready = 1'b0;
    tick();
    tick();
    checks++;
    if (p_mvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid: got %0b expected 0", p_mvalid); end
    checks++;
    if (p_mdata !== 16'sd0) begin errors++; $display("FAIL reset_mdata: got %0d expected 0", p_mdata); end
    checks++;
    if (p_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b expected 0", p_sat); end
    checks++;
    if (p_sready !== 1'b1) begin errors++; $display("FAIL reset_sready: got %0b expected 1", p_sready); end
    checks++;
    if (int'(u_pure.acc) !== 0) begin errors++; $display("FAIL reset_acc: got %0d expected 0", u_pure.acc); end
    clear = 1'b0;
  endtask

  task automatic test_pure_accumulation();
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 16'sd100;
    areset   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (p_mvalid !== 1'b1 || p_mdata !== 16'(100 * i)) begin
        errors++;
        $display("FAIL pure_out%0d: got valid=%0b data=%0d expected valid=1 data=%0d", i, p_mvalid, p_mdata, 100 * i);
      end
    end
    s_tvalid = 1'b0;
    tick();
    checks++;
    if (p_mvalid !== 1'b0) begin errors++; $display("FAIL pure_drain: got valid=%0b expected 0", p_mvalid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 16'sd10;
    tick();
    s_tdata = 16'sd20;
    checks++;
    if (p_mvalid !== 1'b1 || p_mdata !== 16'sd10) begin
      errors++; $display("FAIL bp_first: got valid=%0b data=%0d expected valid=1 data=10", p_mvalid, p_mdata);
    end
    checks++;
    if (p_sready !== 1'b0) begin errors++; $display("FAIL bp_sready_low: got %0b expected 0", p_sready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (p_mvalid !== 1'b1 || p_mdata !== 16'sd10 || p_sready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%0b data=%0d sready=%0b expected 1/10/0", i, p_mvalid, p_mdata, p_sready);
      end
    end
    checks++;
    if (int'(u_pure.acc) !== 10) begin errors++; $display("FAIL bp_acc_hold: got %0d expected 10", u_pure.acc); end
    m_tready = 1'b1;
    #1;
    checks++;
    if (p_sready !== 1'b1) begin errors++; $display("FAIL bp_sready_release: got %0b expected 1", p_sready); end
    tick();
    s_tvalid = 1'b0;
    checks++;
    if (p_mvalid !== 1'b1 || p_mdata !== 16'sd30) begin
      errors++; $display("FAIL bp_no_bubble: got valid=%0b data=%0d expected valid=1 data=30", p_mvalid, p_mdata);
    end
    tick();
    checks++;
    if (p_mvalid !== 1'b0) begin errors++; $display("FAIL bp_drain: got valid=%0b expected 0", p_mvalid); end
  endtask

  task automatic test_leak();
    int exp_l [4] = '{1000, 500, 250, 125};
    do_reset();
    s_tvalid = 1'b1;
    s_tdata  = 16'sd1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      s_tdata = 16'sd0;
      checks++;
      if (l_mvalid !== 1'b1 || l_mdata !== 16'(exp_l[i])) begin
        errors++;
        $display("FAIL leak_out%0d: got valid=%0b data=%0d expected valid=1 data=%0d", i, l_mvalid, l_mdata, exp_l[i]);
      end
    end
    s_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    s_tvalid = 1'b1;
    s_tdata  = 16'sd32767;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        checks++;
        if (s_mdata !== 16'sd32767 || s_sat !== 1'b0) begin
          errors++; $display("FAIL sat_first: got data=%0d sat=%0b expected 32767/0", s_mdata, s_sat);
        end
      end
      if (k == 2) begin
        checks++;
        if (s_mdata !== 16'sd32767 || s_sat !== 1'b1) begin
          errors++; $display("FAIL sat_out_clip: got data=%0d sat=%0b expected 32767/1", s_mdata, s_sat);
        end
      end
      if (k == 16) begin
        checks++;
        if (int'(u_sat.acc) !== 524272) begin errors++; $display("FAIL sat_acc16: got %0d expected 524272", u_sat.acc); end
      end
      if (k == 17) begin
        checks++;
        if (int'(u_sat.acc) !== 524287) begin errors++; $display("FAIL sat_acc17: got %0d expected 524287", u_sat.acc); end
      end
    end
    checks++;
    if (int'(u_sat.acc) !== 524287 || s_mdata !== 16'sd32767 || s_sat !== 1'b1) begin
      errors++; $display("FAIL sat_hold: got acc=%0d data=%0d sat=%0b expected 524287/32767/1", u_sat.acc, s_mdata, s_sat);
    end
    s_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    do_reset();
    s_tvalid = 1'b1;
    s_tdata  = 16'sd500;
    tick();
    clear   = 1'b1;
    s_tdata = 16'sd7;
    tick();
    clear = 1'b0;
    checks++;
    if (p_mdata !== 16'sd7 || p_sat !== 1'b0 || p_mvalid !== 1'b1) begin
      errors++; $display("FAIL clear_with_sample: got data=%0d sat=%0b valid=%0b expected 7/0/1", p_mdata, p_sat, p_mvalid);
    end
    s_tdata = 16'sd32767;
    tick();
    checks++;
    if (p_mdata !== 16'sd32767 || p_sat !== 1'b1) begin
      errors++; $display("FAIL clear_presat: got data=%0d sat=%0b expected 32767/1", p_mdata, p_sat);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (p_mvalid !== 1'b1 || p_mdata !== 16'sd32767 || p_sat !== 1'b0 || int'(u_pure.acc) !== 0) begin
      errors++;
      $display("FAIL clear_alone: got valid=%0b data=%0d sat=%0b acc=%0d expected 1/32767/0/0", p_mvalid, p_mdata, p_sat, u_pure.acc);
    end
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = -16'sd42;
    tick();
    s_tvalid = 1'b0;
    checks++;
    if (p_mvalid !== 1'b1 || p_mdata !== -16'sd42) begin
      errors++; $display("FAIL clear_next: got valid=%0b data=%0d expected 1/-42", p_mvalid, p_mdata);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 16'sd77;
    tick();
    checks++;
    if (p_mvalid !== 1'b1 || p_mdata !== 16'sd77) begin
      errors++; $display("FAIL midrst_pending: got valid=%0b data=%0d expected 1/77", p_mvalid, p_mdata);
    end
    areset = 1'b1;
    tick();
    checks++;
    if (p_mvalid !== 1'b0 || p_mdata !== 16'sd0 || p_sready !== 1'b1) begin
      errors++; $display("FAIL midrst_flush: got valid=%0b data=%0d sready=%0b expected 0/0/1", p_mvalid, p_mdata, p_sready);
    end
    areset   = 1'b0;
    m_tready = 1'b1;
    s_tdata  = 16'sd5;
    tick();
    s_tvalid = 1'b0;
    checks++;
    if (p_mvalid !== 1'b1 || p_mdata !== 16'sd5) begin
      errors++; $display("FAIL midrst_restart: got valid=%0b data=%0d expected 1/5", p_mvalid, p_mdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_pure_accumulation();
    test_backpressure();
    test_leak();
    test_saturation();
    test_clear();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
